// File: rtl/peripheral_block_ram.sv
// Single-port synchronous block RAM with a LATENCY-deep read pipeline.
// Read latency matches the upstream adapter's valid shift register, so read_valid and data_out change on the same edge.
module peripheral_block_ram #(
  parameter int DATAWIDTH    = 1,
  parameter int DATADEPTH    = 1,
  parameter int LATENCY      = 1,
  parameter int ADDRESSWIDTH = (DATADEPTH > 1) ? $clog2(DATADEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    read_en,
  input  logic                    write_en,
  input  logic [ADDRESSWIDTH-1:0] address,
  input  logic [DATAWIDTH-1:0]    data_in,
  output logic [DATAWIDTH-1:0]    data_out
);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $fatal(1, "peripheral_block_ram: LATENCY must be in 1..8");
  end

  localparam logic [ADDRESSWIDTH:0] DEPTH_EXT = (ADDRESSWIDTH+1)'(DATADEPTH);

  logic [DATAWIDTH-1:0] mem [DATADEPTH];
  logic [DATAWIDTH-1:0] rd_data [LATENCY];
  logic [LATENCY-1:0]   rd_vld;
  logic                 in_range;
  logic                 unused_last_vld;

  assign in_range = ({1'b0, address} < DEPTH_EXT);

  // Storage has no reset; strobes are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && write_en && in_range) begin
      mem[address] <= data_in;
    end
  end

  // The last stage doubles as the output register: it loads only when the
  // stage feeding it is valid, so data_out holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rd_data[i] <= '0;
      end
    end else begin
      rd_vld[0] <= read_en;
      if (read_en) begin
        rd_data[0] <= in_range ? mem[address] : '0;
      end
      for (int i = 1; i < LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        if (rd_vld[i-1]) begin
          rd_data[i] <= rd_data[i-1];
        end
      end
    end
  end

  assign data_out        = rd_data[LATENCY-1];
  assign unused_last_vld = rd_vld[LATENCY-1];

endmodule

// File: tb/tb_peripheral_block_ram.sv
// Directed bench for peripheral_block_ram across four parameter sets.
// Instances: 0 = L1/D16, 1 = L2/D16, 2 = L3/D12, 3 = L4/D16, all 8-bit words.
module tb_peripheral_block_ram;

  logic       clk;
  logic       reset_n;
  logic       re   [4];
  logic       we   [4];
  logic [3:0] addr [4];
  logic [7:0] din  [4];
  logic [7:0] dout [4];

  int passed = 0;
  int total  = 0;

  peripheral_block_ram #(.DATAWIDTH(8), .DATADEPTH(16), .LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .read_en(re[0]), .write_en(we[0]),
    .address(addr[0]), .data_in(din[0]), .data_out(dout[0]));
  peripheral_block_ram #(.DATAWIDTH(8), .DATADEPTH(16), .LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .read_en(re[1]), .write_en(we[1]),
    .address(addr[1]), .data_in(din[1]), .data_out(dout[1]));
  peripheral_block_ram #(.DATAWIDTH(8), .DATADEPTH(12), .LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .read_en(re[2]), .write_en(we[2]),
    .address(addr[2]), .data_in(din[2]), .data_out(dout[2]));
  peripheral_block_ram #(.DATAWIDTH(8), .DATADEPTH(16), .LATENCY(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .read_en(re[3]), .write_en(we[3]),
    .address(addr[3]), .data_in(din[3]), .data_out(dout[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    re[k]   = r;
    we[k]   = w;
    addr[k] = a;
    din[k]  = d;
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dout[k] !== 8'h00) $display("FAIL reset_async[%0d]: got %h expected 00", k, dout[k]);
      else passed++;
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (dout[0] !== 8'h00) $display("FAIL reset_idle cycle %0d: got %h expected 00", c, dout[0]);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    drive(1, 1'b0, 1'b1, 4'd3, 8'hA5);
    tick();
    drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
    tick();
    drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
    total++;
    if (dout[1] !== 8'h00) $display("FAIL wr_rd_early: got %h expected 00", dout[1]);
    else passed++;
    tick();
    total++;
    if (dout[1] !== 8'hA5) $display("FAIL wr_rd_data: got %h expected a5", dout[1]);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (dout[1] !== 8'hA5) $display("FAIL wr_rd_hold cycle %0d: got %h expected a5", c, dout[1]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [6];
    exp_seq = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
    drive(2, 1'b0, 1'b1, 4'd0, 8'h11); tick();
    drive(2, 1'b0, 1'b1, 4'd1, 8'h22); tick();
    drive(2, 1'b0, 1'b1, 4'd2, 8'h33); tick();
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(2, 1'b1, 1'b0, 4'(c), 8'h00);
      else       drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
      tick();
      total++;
      if (dout[2] !== exp_seq[c]) $display("FAIL b2b cycle %0d: got %h expected %h", c, dout[2], exp_seq[c]);
      else passed++;
    end
  endtask

  task automatic test_read_during_write();
    drive(0, 1'b0, 1'b1, 4'd5, 8'h0F); tick();
    drive(0, 1'b1, 1'b1, 4'd5, 8'hF0); tick();
    total++;
    if (dout[0] !== 8'h0F) $display("FAIL rdw_old: got %h expected 0f", dout[0]);
    else passed++;
    drive(0, 1'b1, 1'b0, 4'd5, 8'h00); tick();
    total++;
    if (dout[0] !== 8'hF0) $display("FAIL rdw_new: got %h expected f0", dout[0]);
    else passed++;
    drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 12; i++) begin
      drive(2, 1'b0, 1'b1, 4'(i), 8'h40 + 8'(i));
      tick();
    end
    drive(2, 1'b0, 1'b1, 4'd13, 8'h77); tick();
    drive(2, 1'b1, 1'b0, 4'd13, 8'h00); tick();
    drive(2, 1'b0, 1'b0, 4'd0, 8'h00);  tick();
    tick();
    total++;
    if (dout[2] !== 8'h00) $display("FAIL oor_read: got %h expected 00", dout[2]);
    else passed++;
    for (int c = 0; c < 14; c++) begin
      if (c < 12) drive(2, 1'b1, 1'b0, 4'(c), 8'h00);
      else        drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
      tick();
      if (c >= 2) begin
        total++;
        if (dout[2] !== 8'h40 + 8'(c - 2))
          $display("FAIL oor_readback addr %0d: got %h expected %h", c - 2, dout[2], 8'h40 + 8'(c - 2));
        else passed++;
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(3, 1'b0, 1'b1, 4'd3, 8'hA5); tick();
    drive(3, 1'b1, 1'b0, 4'd3, 8'h00); tick();
    drive(3, 1'b0, 1'b0, 4'd0, 8'h00); tick();
    #2 reset_n = 1'b0;
    drive(3, 1'b1, 1'b1, 4'd3, 8'h5A);
    #1;
    total++;
    if (dout[3] !== 8'h00) $display("FAIL flight_async: got %h expected 00", dout[3]);
    else passed++;
    tick();
    drive(3, 1'b0, 1'b0, 4'd0, 8'h00);
    #2 reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (dout[3] !== 8'h00) $display("FAIL flight_discard cycle %0d: got %h expected 00", c, dout[3]);
      else passed++;
    end
    drive(3, 1'b1, 1'b0, 4'd3, 8'h00); tick();
    drive(3, 1'b0, 1'b0, 4'd0, 8'h00); tick();
    tick();
    total++;
    if (dout[3] !== 8'h00) $display("FAIL flight_early: got %h expected 00", dout[3]);
    else passed++;
    tick();
    total++;
    if (dout[3] !== 8'hA5) $display("FAIL flight_preserved: got %h expected a5", dout[3]);
    else passed++;
  endtask

  initial begin
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 4'd0, 8'h00);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_during_write();
    test_out_of_range();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
